unified_mem_arb: RTL and testbench
==================================

Name: unified_mem_arb

Overview:
- Parametrised, byte-addressable unified instruction/data memory for the pipelined RV32 core.
- It replaces the combinational-read single memory with a synchronous one-access-per-cycle array.
- Two requesters share the array: the fetch port (IF stage) and the data port (MEM stage).
- Per-port req/gnt/rvalid handshake; data port has priority; a starvation counter guarantees fetch progress; misaligned or illegal accesses are reported through d_err.

Parameters:
- DEPTH_BYTES, 1024, memory size in bytes; power of 2, at least 16.
- AW, 32, address width of both ports; only the low log2(DEPTH_BYTES) bits index the array.
- STARVE_LIMIT, 4, consecutive data grants allowed while fetch waits; range 1..15.
- INIT_FILE, "", hex image loaded with $readmemh at elaboration if non-empty.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- if_req  in  1  fetch request.
- if_addr  in  AW  fetch byte address.
- if_gnt  out  1  fetch accepted this cycle (combinational).
- if_rvalid  out  1  fetch data valid.
- if_rdata  out  32  fetched instruction word.
- d_req  in  1  data request.
- d_we  in  1  1 = store, 0 = load.
- d_func3  in  3  RV32 load/store funct3.
- d_addr  in  AW  data byte address.
- d_wdata  in  32  store data.
- d_gnt  out  1  data accepted this cycle (combinational).
- d_rvalid  out  1  data response valid; pulses for loads and stores.
- d_rdata  out  32  extended load result; 0 for stores and errors.
- d_err  out  1  qualifies d_rvalid; access was misaligned or had an illegal funct3.

Behaviour:
- Reset: asynchronous and active-low.
  - Asserting rst_n=0 clears if_rvalid, d_rvalid, d_err, if_rdata, d_rdata and the starvation counter, all to 0.
  - A response pending at reset is dropped.
  - Array contents are NOT reset; they retain INIT_FILE or prior contents.
- Addressing:
  - idx = addr mod DEPTH_BYTES; out-of-range addresses wrap silently.
  - Multi-byte accesses use idx, idx+1, ... each taken mod DEPTH_BYTES. The layout is little-endian.
- Fetch access:
  - The full word at {idx[..:2], 2'b00} is read; if_addr[1:0] is ignored.
  - The fetch port never reports an error.
- Arbitration (combinational, one grant per cycle):
  - If only one port requests, that port is granted.
  - If both request: d_gnt=1 unless starve_cnt == STARVE_LIMIT, in which case if_gnt=1.
  - starve_cnt increments on each cycle where both request and data is granted.
  - starve_cnt resets to 0 on any fetch grant, and on any cycle where if_req=0.
- Latency:
  - A request granted in cycle N gives its port's rvalid=1 in cycle N+1, with rdata registered.
  - rvalid is a 1-cycle pulse per grant; back-to-back grants produce back-to-back pulses.
  - There is no backpressure on responses.
- Loads (d_we=0), by func3:
  - 0 LB: byte, sign-extended.
  - 1 LH: halfword, sign-extended.
  - 2 LW: word.
  - 4 LBU: byte, zero-extended.
  - 5 LHU: halfword, zero-extended.
- Stores (d_we=1), by func3:
  - 0 SB: writes byte d_wdata[7:0].
  - 1 SH: writes halfword [15:0].
  - 2 SW: writes word.
  - The write occurs at the rising edge ending grant cycle N.
  - The store response in N+1 has d_rdata=0.
- Errors (no array write, d_rdata=0, d_err=1 with the N+1 pulse):
  - halfword access with idx[0]=1;
  - word access with idx[1:0]!=0;
  - load func3 in {3,6,7};
  - store func3 not in {0,1,2}.
- Ordering:
  - A load or fetch granted in N+1 observes a store granted in N (write-before-read across cycles).
  - A same-cycle collision cannot occur: there is one grant per cycle.
- Inputs of an ungranted port are ignored. The requester must hold req and its inputs until it sees gnt.
- d_err is 0 whenever d_rvalid is 0.

Test Plan:
- Reset mid-operation: INIT_FILE has word 0x00000033 at 0. Fetch 0 granted in cycle 0; rst_n pulses low in cycle 1 → if_rvalid=0 in cycle 1. After release, fetch 0 → if_rvalid=1 in the cycle after its grant, with if_rdata=0x00000033.
- Store/load chain:
  - SW 0xDEADBEEF @100, then LB @103 → 0xFFFFFFDE.
  - LBU @103 → 0x000000DE; LH @102 → 0xFFFFDEAD; LHU @100 → 0x0000BEEF.
  - Each response arrives 1 cycle after grant.
- Write-before-read: SB 0x7F @101 granted in N; LW @100 granted in N+1 → d_rdata=0xDEAD7FEF in N+2.
- Starvation: both ports request continuously for 12 cycles with STARVE_LIMIT=4 → grant pattern D,D,D,D,F repeating; if_rvalid follows each F grant by 1 cycle.
- Errors (each gives d_rvalid=1, d_err=1, d_rdata=0, memory unchanged):
  - LW @102;
  - SH @105;
  - load func3=3;
  - store func3=4.
- Wrap-around: SW 0x11223344 @DEPTH_BYTES+8, then LW @8 → 0x11223344.

Source files
------------

// File: rtl/unified_mem_arb.sv
// Unified byte-addressable instruction/data memory shared by the fetch (IF) and data (MEM) ports.
// Latency: a request granted in cycle N gets its registered rvalid/rdata in cycle N+1.
// Backpressure: combinational per-port gnt, data port first, fetch forced after STARVE_LIMIT
//   consecutive lost arbitrations; responses are never stalled.
// Ports:
//   clk, rst_n                    clock, asynchronous active-low reset
//   if_req/if_addr/if_gnt         fetch request, byte address (low 2 bits ignored), grant
//   if_rvalid/if_rdata            fetch response pulse and instruction word
//   d_req/d_we/d_func3/d_addr/d_wdata  data request (RV32 load/store encoding)
//   d_gnt                         data grant
//   d_rvalid/d_rdata/d_err        data response pulse, extended load data, error flag
module unified_mem_arb #(
   parameter int    DEPTH_BYTES  = 1024,
   parameter int    AW           = 32,
   parameter int    STARVE_LIMIT = 4,
   parameter string INIT_FILE    = ""
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          if_req,
   input  logic [AW-1:0] if_addr,
   output logic          if_gnt,
   output logic          if_rvalid,
   output logic [31:0]   if_rdata,
   input  logic          d_req,
   input  logic          d_we,
   input  logic [2:0]    d_func3,
   input  logic [AW-1:0] d_addr,
   input  logic [31:0]   d_wdata,
   output logic          d_gnt,
   output logic          d_rvalid,
   output logic [31:0]   d_rdata,
   output logic          d_err
);
   localparam int IW = $clog2(DEPTH_BYTES);

   logic [7:0] mem [DEPTH_BYTES];

   // Address bits above the array index (and the fetch byte offset) are
   // intentionally dropped: addresses wrap modulo the array size.
   logic unused_addr_bits;
   assign unused_addr_bits = ^{if_addr, d_addr};

   // ---------------------------------------------------------------- arbitration
   logic [3:0] starve_cnt;
   logic       starve_hit;

   assign starve_hit = if_req && (starve_cnt == 4'(STARVE_LIMIT));
   assign d_gnt      = d_req && !starve_hit;
   assign if_gnt     = if_req && !d_gnt;

   // Counts data wins while fetch is waiting; with if_req high and no fetch
   // grant, the data port necessarily won this cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         starve_cnt <= '0;
      else if (!if_req || if_gnt)
         starve_cnt <= '0;
      else
         starve_cnt <= starve_cnt + 4'd1;
   end

   // ---------------------------------------------------------------- fetch read
   logic [IW-1:0] f_idx0, f_idx1, f_idx2, f_idx3;
   logic [31:0]   f_word;

   assign f_idx0 = {if_addr[IW-1:2], 2'b00};
   assign f_idx1 = f_idx0 + IW'(1);
   assign f_idx2 = f_idx0 + IW'(2);
   assign f_idx3 = f_idx0 + IW'(3);
   assign f_word = {mem[f_idx3], mem[f_idx2], mem[f_idx1], mem[f_idx0]};

   // ---------------------------------------------------------------- data decode
   logic [IW-1:0] d_idx0, d_idx1, d_idx2, d_idx3;
   logic [7:0]    db0, db1, db2, db3;
   logic [1:0]    d_size;
   logic          func_ok;
   logic          misalign;
   logic          d_bad;
   logic [31:0]   ld_ext;
   logic          st_en;

   // Each byte lane wraps independently, so a word at the top of the array
   // would continue at index 0 (only reachable by byte/half accesses, as
   // aligned words never straddle the end).
   assign d_idx0 = d_addr[IW-1:0];
   assign d_idx1 = d_idx0 + IW'(1);
   assign d_idx2 = d_idx0 + IW'(2);
   assign d_idx3 = d_idx0 + IW'(3);
   assign db0    = mem[d_idx0];
   assign db1    = mem[d_idx1];
   assign db2    = mem[d_idx2];
   assign db3    = mem[d_idx3];

   assign d_size = d_func3[1:0];

   always_comb begin
      func_ok = 1'b0;
      if (d_we)
         func_ok = (d_func3 == 3'd0) || (d_func3 == 3'd1) || (d_func3 == 3'd2);
      else
         func_ok = (d_func3 != 3'd3) && (d_func3 != 3'd6) && (d_func3 != 3'd7);
   end

   assign misalign = ((d_size == 2'd1) && d_idx0[0]) ||
                     ((d_size == 2'd2) && (d_idx0[1:0] != 2'b00));
   assign d_bad    = !func_ok || misalign;

   always_comb begin
      ld_ext = 32'h0;
      case (d_func3)
         3'd0:    ld_ext = {{24{db0[7]}}, db0};
         3'd1:    ld_ext = {{16{db1[7]}}, db1, db0};
         3'd2:    ld_ext = {db3, db2, db1, db0};
         3'd4:    ld_ext = {24'h0, db0};
         3'd5:    ld_ext = {16'h0, db1, db0};
         default: ld_ext = 32'h0;
      endcase
   end

   // ---------------------------------------------------------------- array write
   assign st_en = d_gnt && d_we && !d_bad;

   always_ff @(posedge clk) begin
      if (st_en) begin
         mem[d_idx0] <= d_wdata[7:0];
         if (d_size != 2'd0)
            mem[d_idx1] <= d_wdata[15:8];
         if (d_size == 2'd2) begin
            mem[d_idx2] <= d_wdata[23:16];
            mem[d_idx3] <= d_wdata[31:24];
         end
      end
   end

   // ---------------------------------------------------------------- responses
   // Reads sample the array before this edge's write lands; a store granted
   // one cycle earlier has already been written, giving write-before-read.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         if_rvalid <= 1'b0;
         if_rdata  <= 32'h0;
         d_rvalid  <= 1'b0;
         d_err     <= 1'b0;
         d_rdata   <= 32'h0;
      end else begin
         if_rvalid <= if_gnt;
         if (if_gnt)
            if_rdata <= f_word;
         d_rvalid <= d_gnt;
         d_err    <= d_gnt && d_bad;
         if (d_gnt)
            d_rdata <= (d_we || d_bad) ? 32'h0 : ld_ext;
      end
   end

endmodule

// File: tb/tb_unified_mem_arb.sv
// Self-checking bench for unified_mem_arb: directed vector table, hand sequences for
// reset, starvation and error cases, then randomized traffic against a byte-array model.
module tb_unified_mem_arb;
   localparam int DEPTH  = 256;
   localparam int STARVE = 4;

   logic        clk;
   logic        rst_n;
   logic        if_req;
   logic [31:0] if_addr;
   logic        if_gnt;
   logic        if_rvalid;
   logic [31:0] if_rdata;
   logic        d_req;
   logic        d_we;
   logic [2:0]  d_func3;
   logic [31:0] d_addr;
   logic [31:0] d_wdata;
   logic        d_gnt;
   logic        d_rvalid;
   logic [31:0] d_rdata;
   logic        d_err;

   unified_mem_arb #(
      .DEPTH_BYTES (DEPTH),
      .AW          (32),
      .STARVE_LIMIT(STARVE),
      .INIT_FILE   ("")
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .if_req   (if_req),
      .if_addr  (if_addr),
      .if_gnt   (if_gnt),
      .if_rvalid(if_rvalid),
      .if_rdata (if_rdata),
      .d_req    (d_req),
      .d_we     (d_we),
      .d_func3  (d_func3),
      .d_addr   (d_addr),
      .d_wdata  (d_wdata),
      .d_gnt    (d_gnt),
      .d_rvalid (d_rvalid),
      .d_rdata  (d_rdata),
      .d_err    (d_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Reference state: byte image of the array and the fetch-wait counter.
   logic [7:0] m_mem [DEPTH];
   int         m_starve = 0;

   typedef struct {
      logic        we;
      logic [2:0]  f3;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] exp_rdata;
      logic        exp_err;
   } vec_t;

   vec_t vecs [17];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   function automatic logic [31:0] fillw(input int i);
      return 32'h9E3779B9 * 32'(i) + 32'h33;
   endfunction

   function automatic logic [31:0] model_fetch(input logic [31:0] a);
      int          base;
      logic [31:0] w;
      base = int'(a % 32'(DEPTH)) / 4 * 4;
      w = 32'h0;
      for (int k = 0; k < 4; k++) w = w | (32'(m_mem[base + k]) << (8 * k));
      return w;
   endfunction

   task automatic model_data(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                             input logic [31:0] wd, output logic err, output logic [31:0] rd);
      int     n;
      int     idx;
      bit     sgn;
      bit     legal;
      longint v;
      idx = int'(addr % 32'(DEPTH));
      n = 1; sgn = 0; legal = 1;
      if (we) begin
         case (f3)
            3'd0: n = 1;
            3'd1: n = 2;
            3'd2: n = 4;
            default: legal = 0;
         endcase
      end else begin
         case (f3)
            3'd0: begin n = 1; sgn = 1; end
            3'd1: begin n = 2; sgn = 1; end
            3'd2: n = 4;
            3'd4: n = 1;
            3'd5: n = 2;
            default: legal = 0;
         endcase
      end
      err = !legal || (idx % n != 0);
      rd = 32'h0;
      if (!err) begin
         if (we) begin
            for (int k = 0; k < n; k++) m_mem[(idx + k) % DEPTH] = 8'(wd >> (8 * k));
         end else begin
            v = 0;
            for (int k = 0; k < n; k++) v = v + (longint'(m_mem[(idx + k) % DEPTH]) << (8 * k));
            if (sgn && v[8 * n - 1]) v = v - (longint'(1) << (8 * n));
            rd = v[31:0];
         end
      end
   endtask

   // One arbitration cycle: inputs already driven. Checks the grants against the
   // arbitration rules, then the responses one cycle later. Returns the DUT grants.
   task automatic cycle(output logic gf, output logic gd);
      logic        ef, ed, e_err;
      logic [31:0] e_if, e_d;
      #1;
      ed = d_req && !(if_req && m_starve == STARVE);
      ef = if_req && !ed;
      gf = if_gnt;
      gd = d_gnt;
      chk("grant {if,d}", {30'd0, if_gnt, d_gnt}, {30'd0, ef, ed});
      if (!if_req || ef) m_starve = 0;
      else if (if_req && d_req && ed) m_starve++;
      e_if = 32'h0; e_d = 32'h0; e_err = 1'b0;
      if (ef) e_if = model_fetch(if_addr);
      if (ed) model_data(d_we, d_func3, d_addr, d_wdata, e_err, e_d);
      @(posedge clk);
      #1;
      chk("if_rvalid", 32'(if_rvalid), 32'(ef));
      if (ef) chk("if_rdata", if_rdata, e_if);
      chk("d_rvalid", 32'(d_rvalid), 32'(ed));
      chk("d_err", 32'(d_err), 32'(ed && e_err));
      if (ed) chk("d_rdata", d_rdata, e_d);
   endtask

   initial begin
      logic gf, gd;
      logic af, ad;

      // Directed data-port vectors, applied back-to-back with fetch idle.
      vecs[0]  = '{1'b1, 3'd2, 32'd100, 32'hDEADBEEF, 32'h00000000, 1'b0}; // SW
      vecs[1]  = '{1'b0, 3'd0, 32'd103, 32'h0,        32'hFFFFFFDE, 1'b0}; // LB
      vecs[2]  = '{1'b0, 3'd4, 32'd103, 32'h0,        32'h000000DE, 1'b0}; // LBU
      vecs[3]  = '{1'b0, 3'd1, 32'd102, 32'h0,        32'hFFFFDEAD, 1'b0}; // LH
      vecs[4]  = '{1'b0, 3'd5, 32'd100, 32'h0,        32'h0000BEEF, 1'b0}; // LHU
      vecs[5]  = '{1'b1, 3'd0, 32'd101, 32'h0000007F, 32'h00000000, 1'b0}; // SB
      vecs[6]  = '{1'b0, 3'd2, 32'd100, 32'h0,        32'hDEAD7FEF, 1'b0}; // LW right after SB
      vecs[7]  = '{1'b0, 3'd2, 32'd102, 32'h0,        32'h00000000, 1'b1}; // LW misaligned
      vecs[8]  = '{1'b1, 3'd1, 32'd105, 32'h0000FFFF, 32'h00000000, 1'b1}; // SH misaligned
      vecs[9]  = '{1'b0, 3'd2, 32'd104, 32'h0,        fillw(26),    1'b0}; // untouched by SH
      vecs[10] = '{1'b0, 3'd3, 32'd100, 32'h0,        32'h00000000, 1'b1}; // load f3=3
      vecs[11] = '{1'b1, 3'd4, 32'd100, 32'h0,        32'h00000000, 1'b1}; // store f3=4
      vecs[12] = '{1'b0, 3'd2, 32'd100, 32'h0,        32'hDEAD7FEF, 1'b0}; // unchanged
      vecs[13] = '{1'b0, 3'd1, 32'd101, 32'h0,        32'h00000000, 1'b1}; // LH misaligned
      vecs[14] = '{1'b1, 3'd2, 32'(DEPTH + 8), 32'h11223344, 32'h00000000, 1'b0}; // wrap SW
      vecs[15] = '{1'b0, 3'd2, 32'd8,   32'h0,        32'h11223344, 1'b0}; // LW wrapped
      vecs[16] = '{1'b0, 3'd7, 32'd8,   32'h0,        32'h00000000, 1'b1}; // load f3=7

      rst_n = 1'b0;
      if_req = 1'b0; if_addr = 32'h0;
      d_req = 1'b0; d_we = 1'b0; d_func3 = 3'd0; d_addr = 32'h0; d_wdata = 32'h0;
      #1;
      chk("reset if_rvalid", 32'(if_rvalid), 32'h0);
      chk("reset if_rdata", if_rdata, 32'h0);
      chk("reset d_rvalid", 32'(d_rvalid), 32'h0);
      chk("reset d_err", 32'(d_err), 32'h0);
      chk("reset d_rdata", d_rdata, 32'h0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Give the whole array known contents (word 0 = 0x00000033).
      for (int i = 0; i < DEPTH / 4; i++) begin
         d_req = 1'b1; d_we = 1'b1; d_func3 = 3'd2;
         d_addr = 32'(i * 4); d_wdata = fillw(i);
         cycle(gf, gd);
      end
      d_req = 1'b0;

      // Reset in the cycle after a fetch grant drops the pending response.
      if_req = 1'b1; if_addr = 32'h0;
      #1;
      chk("pre-reset if_gnt", 32'(if_gnt), 32'h1);
      @(posedge clk);
      #1;
      if_req = 1'b0;
      rst_n = 1'b0;
      #1;
      chk("mid-reset if_rvalid", 32'(if_rvalid), 32'h0);
      chk("mid-reset if_rdata", if_rdata, 32'h0);
      @(posedge clk);
      #1;
      chk("in-reset if_rvalid", 32'(if_rvalid), 32'h0);
      rst_n = 1'b1;
      m_starve = 0;
      if_req = 1'b1; if_addr = 32'h0;
      cycle(gf, gd);
      chk("refetch after reset", if_rdata, 32'h00000033);
      if_req = 1'b0;

      // Directed table.
      for (int i = 0; i < 17; i++) begin
         d_req = 1'b1; d_we = vecs[i].we; d_func3 = vecs[i].f3;
         d_addr = vecs[i].addr; d_wdata = vecs[i].wdata;
         cycle(gf, gd);
         chk($sformatf("vec%0d d_rdata", i), d_rdata, vecs[i].exp_rdata);
         chk($sformatf("vec%0d d_err", i), 32'(d_err), 32'(vecs[i].exp_err));
      end
      d_req = 1'b0;

      // Both ports requesting continuously: D,D,D,D,F repeating.
      if_req = 1'b1; if_addr = 32'h40;
      d_req = 1'b1; d_we = 1'b0; d_func3 = 3'd2; d_addr = 32'h20;
      for (int c = 0; c < 12; c++) begin
         cycle(gf, gd);
         chk($sformatf("starve c%0d d_gnt", c), 32'(gd), 32'((c % 5) != 4));
         chk($sformatf("starve c%0d if_gnt", c), 32'(gf), 32'((c % 5) == 4));
      end
      if_req = 1'b0; d_req = 1'b0;
      cycle(gf, gd);

      // Randomized traffic; an ungranted requester holds its request.
      af = 1'b0; ad = 1'b0;
      for (int n = 0; n < 400; n++) begin
         if (!(if_req && !af)) begin
            if_req = ($urandom_range(0, 3) != 0);
            if_addr = $urandom();
         end
         if (!(d_req && !ad)) begin
            d_req = ($urandom_range(0, 2) != 0);
            d_we = 1'($urandom_range(0, 1));
            d_func3 = 3'($urandom_range(0, 7));
            d_addr = 32'($urandom_range(0, 63)) + 32'(DEPTH) * 32'($urandom_range(0, 7));
            d_wdata = $urandom();
         end
         cycle(af, ad);
      end
      if_req = 1'b0; d_req = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
